// File: rtl/router_pkg.sv
// Shared definitions for the 1-to-3 router.
// Used by the packet FSM, the synchronizer and the register stage.
package router_pkg;

  localparam int ADDR_WIDTH = 2;
  localparam int NUM_DEST   = 3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

endpackage

// File: rtl/router_fsm.sv
// Packet-level controller: decodes the header destination and sequences
// header, payload and parity writes into the addressed FIFO.
module router_fsm
  import router_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [ADDR_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  fifo_empty_0,
  input  logic                  fifo_empty_1,
  input  logic                  fifo_empty_2,
  input  logic                  soft_reset_0,
  input  logic                  soft_reset_1,
  input  logic                  soft_reset_2,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  write_enb_reg,
  output logic                  rst_int_reg,
  output logic                  busy,
  output state_e                state_dbg_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;

  logic empty_in;    // empty flag of the FIFO named by the incoming header
  logic empty_addr;  // empty flag of the latched destination
  logic soft_addr;   // timeout reset of the latched destination

  // Valid/ready: the source may present a byte only while busy is low; a
  // header is taken in DECODE_ADDRESS whenever pkt_valid is high, and a
  // payload byte is written on every cycle write_enb_reg is high.

  always_comb begin
    empty_in = 1'b0;
    case (data_in)
      2'd0:    empty_in = fifo_empty_0;
      2'd1:    empty_in = fifo_empty_1;
      2'd2:    empty_in = fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
  end

  // An invalid latched address selects no FIFO, so it never sees a soft reset.
  always_comb begin
    empty_addr = 1'b0;
    soft_addr  = 1'b0;
    case (addr_q)
      2'd0: begin
        empty_addr = fifo_empty_0;
        soft_addr  = soft_reset_0;
      end
      2'd1: begin
        empty_addr = fifo_empty_1;
        soft_addr  = soft_reset_1;
      end
      2'd2: begin
        empty_addr = fifo_empty_2;
        soft_addr  = soft_reset_2;
      end
      default: begin
        empty_addr = 1'b0;
        soft_addr  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    if (state_q == DECODE_ADDRESS && pkt_valid) begin
      addr_d = data_in;
    end

    if (soft_addr) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != ADDR_INVALID) begin
            state_d = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (empty_addr) state_d = LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= ADDR_INVALID;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Moore outputs, decoded from the registered state only.
  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    state_dbg_o   = state_q;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: per-scenario tasks push the expected
// post-edge output vector into a queue and compare it one edge later.
module tb_router_fsm;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
  state_e     state_dbg;

  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  router_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty_0 (fifo_empty_0),
    .fifo_empty_1 (fifo_empty_1),
    .fifo_empty_2 (fifo_empty_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy),
    .state_dbg_o  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- model and driver tasks ----------------
  // Expected {state, detect_add, lfd, ld, laf, full, wen, rst_int, busy}.
  function automatic logic [10:0] outs_for(state_e s);
    logic da, lfd, ld, laf, ffs, lp, wte, cpe;
    da  = (s == DECODE_ADDRESS);
    lfd = (s == LOAD_FIRST_DATA);
    ld  = (s == LOAD_DATA);
    laf = (s == LOAD_AFTER_FULL);
    ffs = (s == FIFO_FULL_STATE);
    lp  = (s == LOAD_PARITY);
    wte = (s == WAIT_TILL_EMPTY);
    cpe = (s == CHECK_PARITY_ERROR);
    return {s, da, lfd, ld, laf, ffs, (ld | lp | laf), cpe,
            (lfd | lp | ffs | laf | wte | cpe)};
  endfunction

  function automatic logic [10:0] observed();
    return {state_dbg, detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic idle_inputs();
    reset         = 1'b0;
    pkt_valid     = 1'b0;
    data_in       = 2'b00;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
  endtask

  task automatic push_exp(state_e s);
    exp_q.push_back(outs_for(s));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [10:0] exp, got;
    idle_inputs();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      reset = (c < 2);
      push_exp(DECODE_ADDRESS);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_normal_packet();
    logic [10:0] exp, got;
    int wen_cycles = 0;
    state_e seq[8] = '{LOAD_FIRST_DATA, LOAD_DATA, LOAD_DATA, LOAD_DATA,
                       LOAD_DATA, LOAD_PARITY, CHECK_PARITY_ERROR,
                       DECODE_ADDRESS};
    idle_inputs();
    data_in = 2'b01;
    for (int c = 0; c < 8; c++) begin
      pkt_valid = (c < 5);
      push_exp(seq[c]);
      tick();
      if (write_enb_reg) wen_cycles++;
      exp = exp_q.pop_front();
      got = observed();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL normal_pkt cyc %0d: got %b expected %b", c, got, exp);
      end
    end
    n_checks++;
    if (wen_cycles !== 5) begin
      n_fail++;
      $display("FAIL normal_pkt_wen_count: got %0d expected 5", wen_cycles);
    end
  endtask

  task automatic test_busy_dest();
    logic [10:0] exp, got;
    state_e s;
    idle_inputs();
    fifo_empty_2 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      pkt_valid = (c != 11);
      data_in   = (c == 0) ? 2'b10 : 2'b00;
      // Non-addressed empty flags toggle while waiting.
      if (c >= 1 && c <= 8) begin
        fifo_empty_0 = c[0];
        fifo_empty_1 = ~c[0];
      end else begin
        fifo_empty_0 = 1'b1;
        fifo_empty_1 = 1'b1;
      end
      fifo_empty_2 = (c >= 9);
      if (c <= 8)       s = WAIT_TILL_EMPTY;
      else if (c == 9)  s = LOAD_FIRST_DATA;
      else if (c == 10) s = LOAD_DATA;
      else if (c == 11) s = LOAD_PARITY;
      else if (c == 12) s = CHECK_PARITY_ERROR;
      else              s = DECODE_ADDRESS;
      if (c >= 11) pkt_valid = 1'b0;
      push_exp(s);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL busy_dest cyc %0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_full_mid_packet();
    logic [10:0] exp, got;
    state_e seq[14] = '{LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
                        FIFO_FULL_STATE, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                        LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                        LOAD_PARITY, CHECK_PARITY_ERROR, FIFO_FULL_STATE,
                        LOAD_AFTER_FULL, DECODE_ADDRESS};
    idle_inputs();
    data_in = 2'b00;
    for (int c = 0; c < 14; c++) begin
      pkt_valid     = (c < 9);
      fifo_full     = (c >= 2 && c <= 4) || (c == 7) || (c == 11);
      low_pkt_valid = (c == 9);
      parity_done   = (c == 13);
      push_exp(seq[c]);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL full_mid_pkt cyc %0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_soft_reset();
    logic [10:0] exp, got;
    state_e seq[9] = '{WAIT_TILL_EMPTY, WAIT_TILL_EMPTY, WAIT_TILL_EMPTY,
                       DECODE_ADDRESS, DECODE_ADDRESS, LOAD_FIRST_DATA,
                       LOAD_DATA, DECODE_ADDRESS, DECODE_ADDRESS};
    idle_inputs();
    for (int c = 0; c < 9; c++) begin
      pkt_valid    = (c == 0) || (c >= 5 && c <= 7);
      data_in      = (c >= 5) ? 2'b01 : 2'b00;
      fifo_empty_0 = (c >= 4);
      soft_reset_1 = (c == 1) || (c == 7);
      soft_reset_2 = (c == 2);
      soft_reset_0 = (c == 3);
      fifo_full    = (c == 7);
      push_exp(seq[c]);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL soft_reset cyc %0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_invalid_addr();
    logic [10:0] exp, got;
    state_e seq[10] = '{DECODE_ADDRESS, DECODE_ADDRESS, DECODE_ADDRESS,
                        DECODE_ADDRESS, DECODE_ADDRESS, LOAD_FIRST_DATA,
                        LOAD_DATA, LOAD_PARITY, CHECK_PARITY_ERROR,
                        DECODE_ADDRESS};
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      pkt_valid    = (c <= 6);
      data_in      = (c < 5) ? 2'b11 : 2'b00;
      soft_reset_0 = 1'b0;
      soft_reset_1 = (c < 5) && ($urandom_range(0, 1) == 1);
      soft_reset_2 = (c < 5) && ($urandom_range(0, 1) == 1);
      push_exp(seq[c]);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL invalid_addr cyc %0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp, got;
    state_e seq[10] = '{LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY,
                        CHECK_PARITY_ERROR, DECODE_ADDRESS, LOAD_FIRST_DATA,
                        LOAD_DATA, LOAD_PARITY, CHECK_PARITY_ERROR,
                        DECODE_ADDRESS};
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      pkt_valid = (c <= 1) || (c >= 4 && c <= 6);
      data_in   = (c < 4) ? 2'b10 : 2'b01;
      push_exp(seq[c]);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_normal_packet();
    test_busy_dest();
    test_full_mid_packet();
    test_soft_reset();
    test_invalid_addr();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
